led_pattern_gen: RTL and testbench

//   Multi-channel LED pattern generator, successor to the single-LED heartbeat.
//   A shared prescaler produces a tick. Each channel independently runs OFF, ON,

---
 rtl/led_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   Multi-channel LED pattern generator. A shared prescaler produces a tick
//   every CLK_HZ/TICK_HZ clocks. Each channel runs one of four modes: OFF, ON,
//   BLINK (square wave of a programmable period in ticks) or BREATHE (a
//   triangular PWM brightness ramp). Channels are reconfigured at run time
//   through a valid/ready config port.
//
// Ports
//   clk         in   board clock
//   reset_n     in   synchronous active-low reset
//   cfg_valid   in   config request
//   cfg_ready   out  config can be accepted (high from the first cycle after reset)
//   cfg_ch      in   target channel index ($clog2(N_CH)+1 bits)
//   cfg_mode    in   0=OFF 1=ON 2=BLINK 3=BREATHE
//   cfg_period  in   BLINK: full period in ticks; BREATHE: ticks per brightness step
//   cfg_err     out  one-cycle pulse after accepting an out-of-range cfg_ch
//   tick        out  one-cycle prescaler pulse
//   led         out  registered LED drive, polarity set by LED_ACTIVE_LOW
// -----------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int N_CH           = 4,
    parameter int PERIOD_W       = 16,
    parameter int PWM_BITS       = 8,
    parameter int DEF_PERIOD     = 1000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH):0]   cfg_ch,
    input  logic [1:0]              cfg_mode,
    input  logic [PERIOD_W-1:0]     cfg_period,
    output logic                    cfg_err,
    output logic                    tick,
    output logic [N_CH-1:0]         led
);

    localparam int CH_W  = $clog2(N_CH) + 1;
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PSC_W-1:0]    PSC_MAX = PSC_W'(DIV - 1);
    localparam logic [CH_W-1:0]     N_CH_V  = CH_W'(N_CH);
    localparam logic [PWM_BITS-1:0] BR_MAX  = '1;
    localparam logic [PERIOD_W-1:0] DEF_P   = PERIOD_W'(DEF_PERIOD);
    localparam logic [N_CH-1:0]     DARK    = LED_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_ON      = 2'd1,
        M_BLINK   = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    // A zero period would make the wrap compare underflow, so it is stored as 1.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

    // Lit for the first ceil(P/2) ticks of the period; widened so P+1 cannot wrap.
    function automatic logic blink_lit(input logic [PERIOD_W-1:0] c,
                                       input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W:0] half;
        half = ({1'b0, p} + (PERIOD_W+1)'(1)) >> 1;
        return ({1'b0, c} < half);
    endfunction

    // One brightness step, returned as {dir, br}. At either endpoint the step
    // only flips the direction, so each endpoint is held for one extra step.
    function automatic logic [PWM_BITS:0] breathe_step(input logic              d,
                                                       input logic [PWM_BITS-1:0] b);
        if (!d) begin
            return (b == BR_MAX) ? {1'b1, b} : {1'b0, b + PWM_BITS'(1)};
        end
        return (b == '0) ? {1'b0, b} : {1'b1, b - PWM_BITS'(1)};
    endfunction

    logic [PSC_W-1:0]    psc;
    logic [PWM_BITS-1:0] pc;
    logic                accept;
    logic                ch_ok;
    logic [N_CH-1:0]     lit;

    mode_t               mode [N_CH];
    logic [PERIOD_W-1:0] per  [N_CH];
    logic [PERIOD_W-1:0] cnt  [N_CH];
    logic [PWM_BITS-1:0] br   [N_CH];
    logic                dir  [N_CH];

    assign accept = cfg_valid & cfg_ready;
    assign ch_ok  = (cfg_ch < N_CH_V);

    // Prescaler, shared PWM counter and config handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            psc       <= '0;
            tick      <= 1'b0;
            pc        <= '0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            tick      <= (psc == PSC_MAX);
            psc       <= (psc == PSC_MAX) ? '0 : psc + PSC_W'(1);
            pc        <= pc + PWM_BITS'(1);
            cfg_ready <= 1'b1;
            cfg_err   <= accept & ~ch_ok;
        end
    end

    // Per-channel state. A config write to a channel takes priority over a
    // coincident tick, which is then lost for that channel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!reset_n) begin
                mode[i] <= (i == 0) ? M_BLINK : M_OFF;
                per[i]  <= (i == 0) ? clamp_period(DEF_P) : PERIOD_W'(1);
                cnt[i]  <= '0;
                br[i]   <= '0;
                dir[i]  <= 1'b0;
            end else if (accept && ch_ok && (cfg_ch == CH_W'(i))) begin
                mode[i] <= mode_t'(cfg_mode);
                per[i]  <= clamp_period(cfg_period);
                cnt[i]  <= '0;
                br[i]   <= '0;
                dir[i]  <= 1'b0;
            end else if (tick) begin
                case (mode[i])
                    M_BLINK: begin
                        cnt[i] <= (cnt[i] == per[i] - PERIOD_W'(1)) ? '0 : cnt[i] + PERIOD_W'(1);
                    end
                    M_BREATHE: begin
                        if (cnt[i] == per[i] - PERIOD_W'(1)) begin
                            cnt[i]          <= '0;
                            {dir[i], br[i]} <= breathe_step(dir[i], br[i]);
                        end else begin
                            cnt[i] <= cnt[i] + PERIOD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode[i])
                M_ON:      lit[i] = 1'b1;
                M_BLINK:   lit[i] = blink_lit(cnt[i], per[i]);
                M_BREATHE: lit[i] = (pc < br[i]);
                default:   lit[i] = 1'b0;
            endcase
        end
    end

    // Output register: keeps cfg_* off any combinational path to the pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led <= DARK;
        end else begin
            led <= LED_ACTIVE_LOW ? ~lit : lit;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Bench for led_pattern_gen at CLK_HZ=100, TICK_HZ=10 (tick every 10 clk),
//   N_CH=4, PWM_BITS=4, DEF_PERIOD=4. A behavioural reference model steps on
//   every rising edge and queues the expected outputs; each scenario task pops
//   one entry per falling edge and compares, and adds its own targeted checks.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

    typedef struct packed {
        logic [3:0] led;
        logic       tick;
        logic       err;
        logic       ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period;
    logic        cfg_err;
    logic        tick;
    logic [3:0]  led;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    // reference model state
    int         m_psc, m_pc;
    logic       m_tick, m_err, m_ready, m_acc;
    logic [3:0] m_led, m_lit;
    logic [1:0] m_mode [4];
    int         m_per  [4];
    int         m_cnt  [4];
    int         m_br   [4];
    logic       m_dir  [4];
    exp_t       m_e;

    led_pattern_gen #(
        .CLK_HZ(100), .TICK_HZ(10), .N_CH(4), .PERIOD_W(16),
        .PWM_BITS(4), .DEF_PERIOD(4), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_err(cfg_err), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_psc = 0; m_pc = 0; m_tick = 0; m_err = 0; m_ready = 0; m_led = 4'hF;
                for (int i = 0; i < 4; i++) begin
                    m_mode[i] = (i == 0) ? 2'd2 : 2'd0;
                    m_per[i] = 4; m_cnt[i] = 0; m_br[i] = 0; m_dir[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    case (m_mode[i])
                        2'd1:    m_lit[i] = 1'b1;
                        2'd2:    m_lit[i] = (m_cnt[i] < (m_per[i] + 1) / 2);
                        2'd3:    m_lit[i] = (m_pc < m_br[i]);
                        default: m_lit[i] = 1'b0;
                    endcase
                end
                m_acc = cfg_valid && m_ready;
                for (int i = 0; i < 4; i++) begin
                    if (m_acc && int'(cfg_ch) == i) begin
                        m_mode[i] = cfg_mode;
                        m_per[i]  = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
                        m_cnt[i] = 0; m_br[i] = 0; m_dir[i] = 1'b0;
                    end else if (m_tick) begin
                        if (m_mode[i] == 2'd2) begin
                            m_cnt[i] = (m_cnt[i] + 1) % m_per[i];
                        end else if (m_mode[i] == 2'd3) begin
                            if (m_cnt[i] + 1 >= m_per[i]) begin
                                m_cnt[i] = 0;
                                if (!m_dir[i]) begin
                                    if (m_br[i] == 15) m_dir[i] = 1'b1;
                                    else m_br[i] = m_br[i] + 1;
                                end else begin
                                    if (m_br[i] == 0) m_dir[i] = 1'b0;
                                    else m_br[i] = m_br[i] - 1;
                                end
                            end else begin
                                m_cnt[i] = m_cnt[i] + 1;
                            end
                        end
                    end
                end
                m_err   = m_acc && (int'(cfg_ch) >= 4);
                m_tick  = (m_psc == 9);
                m_psc   = (m_psc + 1) % 10;
                m_pc    = (m_pc + 1) % 16;
                m_ready = 1'b1;
                m_led   = ~m_lit;
            end
            m_e.led = m_led; m_e.tick = m_tick; m_e.err = m_err; m_e.ready = m_ready;
            sb.push_back(m_e);
        end
    end

    task automatic test_reset();
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL reset_sb: got %b want %b", {led, tick, cfg_err, cfg_ready}, e);
            end
        end
        total++;
        if ({led, tick, cfg_err, cfg_ready} !== 7'b1111_0_0_0) begin
            bad++;
            $display("FAIL reset_state: got %b want 1111000", {led, tick, cfg_err, cfg_ready});
        end
    endtask

    task automatic test_release();
        exp_t e;
        int first_tick = -1;
        int lit_a = 0, lit_b = 0;
        reset_n = 1'b1;
        for (int n = 1; n <= 81; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL release_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (tick === 1'b1 && first_tick < 0) first_tick = n;
            if (n >= 2 && n <= 41 && led[0] === 1'b0) lit_a++;
            if (n >= 42 && led[0] === 1'b0) lit_b++;
            if (led[3:1] !== 3'b111) begin
                bad++; total++;
                $display("FAIL release_off n=%0d: got %b want 111", n, led[3:1]);
            end
        end
        total++;
        if (first_tick != 10) begin
            bad++;
            $display("FAIL first_tick: got %0d want 10", first_tick);
        end
        total++;
        if (lit_a != 20 || lit_b != 20) begin
            bad++;
            $display("FAIL ch0_blink_duty: got %0d/%0d want 20/20", lit_a, lit_b);
        end
    endtask

    task automatic test_cfg_on();
        exp_t e;
        logic want2 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: begin cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'd1; cfg_period = 16'd0; end
                2: begin cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'd0; end
                default: cfg_valid = 1'b0;
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL cfg_on_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            total++;
            if (led[2] !== want2[n] || cfg_ready !== 1'b1) begin
                bad++;
                $display("FAIL cfg_on_led2 n=%0d: got led2=%b ready=%b want led2=%b ready=1",
                         n, led[2], cfg_ready, want2[n]);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_blink();
        exp_t e;
        int lit_cnt = 0;
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd2; cfg_period = 16'd0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL blink_p0_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (n >= 1 && led[1] !== 1'b0) begin
                bad++; total++;
                $display("FAIL blink_p0_lit n=%0d: got %b want 0", n, led[1]);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd2; cfg_period = 16'd3;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL blink_p3_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (n >= 15 && n <= 44 && led[1] === 1'b0) lit_cnt++;
        end
        total++;
        if (lit_cnt != 20) begin
            bad++;
            $display("FAIL blink_p3_duty: got %0d want 20", lit_cnt);
        end
    endtask

    task automatic test_breathe();
        exp_t e;
        int found = 0;
        int lit_cnt = 0;
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'd3; cfg_period = 16'd1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL breathe_p1_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'd3; cfg_period = 16'd4;
        for (int n = 0; n < 600 && found == 0; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL breathe_p4_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (m_br[3] == 8 && m_cnt[3] == 1) found = 1;
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL breathe_reach8: got timeout want br=8 within 600 clk");
        end else begin
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                e = sb.pop_front();
                total++;
                if ({led, tick, cfg_err, cfg_ready} !== e) begin
                    bad++;
                    $display("FAIL breathe_duty_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
                end
                if (led[3] === 1'b0) lit_cnt++;
            end
            total++;
            if (lit_cnt != 8) begin
                bad++;
                $display("FAIL breathe_duty8: got %0d want 8", lit_cnt);
            end
        end
    endtask

    task automatic test_tick_collision();
        exp_t e;
        int seen = 0;
        int pulses = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL coll_wait_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (tick === 1'b1) seen = 1;
        end
        total++;
        if (seen == 0) begin
            bad++;
            $display("FAIL coll_tick_seen: got none want tick within 20 clk");
        end
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'd2; cfg_period = 16'd4;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL coll_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if ((n >= 2 && n <= 21 && led[0] !== 1'b0) || (n == 22 && led[0] !== 1'b1)) begin
                bad++; total++;
                $display("FAIL coll_led0 n=%0d: got %b want %b", n, led[0], (n == 22) ? 1'b1 : 1'b0);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_mode = 2'd1; cfg_period = 16'd7;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL bad_ch_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (cfg_err === 1'b1) pulses++;
            if (n == 1 && cfg_err !== 1'b1) begin
                bad++; total++;
                $display("FAIL bad_ch_err: got %b want 1", cfg_err);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL bad_ch_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 250; n++) begin
            if (n < 150) begin
                cfg_valid  = 1'($urandom_range(0, 1));
                cfg_ch     = 3'($urandom_range(0, 5));
                cfg_mode   = 2'($urandom_range(0, 3));
                cfg_period = 16'($urandom_range(0, 5));
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL b2b_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'd3; cfg_period = 16'd1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL rmid_run_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
        end
        reset_n = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'd1; cfg_period = 16'd2;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL rmid_rst_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            total++;
            if (led !== 4'hF || cfg_ready !== 1'b0) begin
                bad++;
                $display("FAIL rmid_rst_state n=%0d: got led=%b ready=%b want led=1111 ready=0",
                         n, led, cfg_ready);
            end
        end
        reset_n = 1'b1;
        cfg_valid = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({led, tick, cfg_err, cfg_ready} !== e) begin
                bad++;
                $display("FAIL rmid_post_sb n=%0d: got %b want %b", n, {led, tick, cfg_err, cfg_ready}, e);
            end
            if (led[3:1] !== 3'b111 || (n == 1 && led[0] !== 1'b0)) begin
                bad++; total++;
                $display("FAIL rmid_post_led n=%0d: got %b want 111%s", n, led, (n == 1) ? "0" : "x");
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 3'd0;
        cfg_mode   = 2'd0;
        cfg_period = 16'd0;
        test_reset();
        test_release();
        test_cfg_on();
        test_blink();
        test_breathe();
        test_tick_collision();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
